// File: rtl/regfile_mp.sv
// regfile_mp: general-purpose register file for the ID stage, with a
// producer scoreboard.
//
// Register 0 always reads as zero and cannot be written. When BYPASS=1, a
// write in the current cycle is forwarded to any read port that addresses
// the same register. The scoreboard keeps one busy bit per register: an
// issue sets the bit for its destination, and a writeback clears it.
//
// Ports:
//   clk_i        clock; all state changes on the rising edge
//   rst_i        synchronous reset, active low; also forces read outputs to 0
//   rdaddr_i     NUM_RD packed read addresses; port k at [k*ADDR_W +: ADDR_W]
//   rddata_o     NUM_RD packed read data; port k at [k*DATA_W +: DATA_W]
//   rdbusy_o     per-port flag: the operand has a pending producer
//   regwrite_i   writeback enable
//   wraddr_i     writeback address
//   wrdata_i     writeback data
//   issue_i      an instruction with a destination issued this cycle
//   issueaddr_i  destination of the issued instruction
//   busy_o       raw scoreboard vector; bit n is set while register n is busy
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int BYPASS = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_RD*ADDR_W-1:0] rdaddr_i,
  output logic [NUM_RD*DATA_W-1:0] rddata_o,
  output logic [NUM_RD-1:0]        rdbusy_o,
  input  logic                     regwrite_i,
  input  logic [ADDR_W-1:0]        wraddr_i,
  input  logic [DATA_W-1:0]        wrdata_i,
  input  logic                     issue_i,
  input  logic [ADDR_W-1:0]        issueaddr_i,
  output logic [(1<<ADDR_W)-1:0]   busy_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_next;
  logic              wr_en;

  // Writes to register 0 are dropped here, so reg[0] keeps its reset value.
  assign wr_en = regwrite_i && (wraddr_i != '0);

  // Scoreboard update. The issue is applied after the clear, so a new
  // producer wins over the writeback of an older one.
  always_comb begin
    busy_next = busy;
    if (regwrite_i) busy_next[wraddr_i] = 1'b0;
    if (issue_i)    busy_next[issueaddr_i] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int n = 0; n < DEPTH; n++) regs[n] <= '0;
      busy <= '0;
    end else begin
      if (wr_en) regs[wraddr_i] <= wrdata_i;
      busy <= busy_next;
    end
  end

  assign busy_o = busy;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              wr_hit;
    logic              iss_hit;

    assign addr    = rdaddr_i[k*ADDR_W +: ADDR_W];
    assign wr_hit  = (BYPASS != 0) && regwrite_i && (wraddr_i == addr);
    assign iss_hit = issue_i && (issueaddr_i == addr);

    always_comb begin
      rddata_o[k*DATA_W +: DATA_W] = regs[addr];
      if (wr_hit) rddata_o[k*DATA_W +: DATA_W] = wrdata_i;
      if (addr == '0 || !rst_i) rddata_o[k*DATA_W +: DATA_W] = '0;
    end

    // Forwarded data is valid, so no stall is needed. The exception is a
    // simultaneous issue to the same register: it makes the register busy again.
    always_comb begin
      rdbusy_o[k] = busy[addr];
      if (wr_hit && !iss_hit) rdbusy_o[k] = 1'b0;
      if (!rst_i) rdbusy_o[k] = 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [NR*AW-1:0] rdaddr = '0;
  logic           regwrite = 1'b0;
  logic [AW-1:0]  wraddr = '0;
  logic [DW-1:0]  wrdata = '0;
  logic           issue = 1'b0;
  logic [AW-1:0]  issueaddr = '0;

  logic [NR*DW-1:0] rddata_b, rddata_n;
  logic [NR-1:0]    rdbusy_b, rdbusy_n;
  logic [31:0]      busy_b, busy_n;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // dut_b has bypass; dut_n has no bypass. Both get the same stimulus.
  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(1)) dut_b (
    .clk_i(clk), .rst_i(rst), .rdaddr_i(rdaddr), .rddata_o(rddata_b),
    .rdbusy_o(rdbusy_b), .regwrite_i(regwrite), .wraddr_i(wraddr),
    .wrdata_i(wrdata), .issue_i(issue), .issueaddr_i(issueaddr), .busy_o(busy_b));

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(0)) dut_n (
    .clk_i(clk), .rst_i(rst), .rdaddr_i(rdaddr), .rddata_o(rddata_n),
    .rdbusy_o(rdbusy_n), .regwrite_i(regwrite), .wraddr_i(wraddr),
    .wrdata_i(wrdata), .issue_i(issue), .issueaddr_i(issueaddr), .busy_o(busy_n));

  // The bench always sits 1 time unit after a rising edge. Inputs are
  // driven there and outputs are sampled 1 unit later, well before the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic i, input logic [AW-1:0] ia,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    regwrite = w; wraddr = wa; wrdata = wd; issue = i; issueaddr = ia;
    rdaddr = {a1, a0};
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b1;
    drive(1, 5, 32'hDEADBEEF, 1, 5, 5, 6);
    tick();
    drive(0, 0, 0, 0, 0, 5, 6);
    vectors++;
    if (rddata_b[31:0] !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL preload_data got %h want deadbeef", rddata_b[31:0]);
    end
    vectors++;
    if (busy_b[5] !== 1'b1 || rdbusy_b[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL preload_busy got busy5=%b rdbusy0=%b want 1 1", busy_b[5], rdbusy_b[0]);
    end
    rst = 1'b0;
    drive(1, 6, 32'h77, 1, 6, 5, 6);
    vectors++;
    if (rddata_b !== '0 || rddata_n !== '0) begin
      miscompares++;
      $display("FAIL reset_rddata got %h %h want 0", rddata_b, rddata_n);
    end
    vectors++;
    if (rdbusy_b !== '0 || rdbusy_n !== '0) begin
      miscompares++;
      $display("FAIL reset_rdbusy got %b %b want 0", rdbusy_b, rdbusy_n);
    end
    tick();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 5, 6);
    vectors++;
    if (rddata_b !== '0 || rddata_n !== '0) begin
      miscompares++;
      $display("FAIL post_reset_rddata got %h %h want 0", rddata_b, rddata_n);
    end
    vectors++;
    if (busy_b !== '0 || busy_n !== '0) begin
      miscompares++;
      $display("FAIL post_reset_busy got %h %h want 0", busy_b, busy_n);
    end
  endtask

  task automatic test_zero_reg();
    drive(1, 0, 32'h12345678, 1, 0, 0, 0);
    vectors++;
    if (rddata_b !== '0 || rddata_n !== '0) begin
      miscompares++;
      $display("FAIL zero_bypass got %h %h want 0", rddata_b, rddata_n);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    vectors++;
    if (rddata_b !== '0 || rddata_n !== '0) begin
      miscompares++;
      $display("FAIL zero_read got %h %h want 0", rddata_b, rddata_n);
    end
    vectors++;
    if (busy_b !== '0 || busy_n !== '0 || rdbusy_b !== '0) begin
      miscompares++;
      $display("FAIL zero_busy got %h %h %b want 0", busy_b, busy_n, rdbusy_b);
    end
  endtask

  task automatic test_basic();
    drive(1, 7, 32'hA5A5A5A5, 0, 0, 1, 2);
    tick();
    drive(0, 0, 0, 0, 0, 7, 7);
    vectors++;
    if (rddata_b !== {2{32'hA5A5A5A5}} || rddata_n !== {2{32'hA5A5A5A5}}) begin
      miscompares++;
      $display("FAIL basic_read got %h %h want a5a5a5a5 on all ports", rddata_b, rddata_n);
    end
    vectors++;
    if (rdbusy_b !== 2'b00 || rdbusy_n !== 2'b00) begin
      miscompares++;
      $display("FAIL basic_rdbusy got %b %b want 00", rdbusy_b, rdbusy_n);
    end
  endtask

  task automatic test_bypass();
    drive(1, 3, 32'h1, 0, 0, 0, 7);
    tick();
    drive(1, 3, 32'h2, 0, 0, 3, 7);
    vectors++;
    if (rddata_b[31:0] !== 32'h2) begin
      miscompares++;
      $display("FAIL bypass_on got %h want 2", rddata_b[31:0]);
    end
    vectors++;
    if (rddata_n[31:0] !== 32'h1) begin
      miscompares++;
      $display("FAIL bypass_off got %h want 1", rddata_n[31:0]);
    end
    vectors++;
    if (rddata_b[63:32] !== 32'hA5A5A5A5) begin
      miscompares++;
      $display("FAIL bypass_other_port got %h want a5a5a5a5", rddata_b[63:32]);
    end
    tick();
    drive(0, 0, 0, 0, 0, 3, 3);
    vectors++;
    if (rddata_b !== {2{32'h2}} || rddata_n !== {2{32'h2}}) begin
      miscompares++;
      $display("FAIL bypass_next got %h %h want 2 on all ports", rddata_b, rddata_n);
    end
  endtask

  task automatic test_scoreboard();
    drive(0, 0, 0, 1, 9, 0, 9);
    vectors++;
    if (rdbusy_b[1] !== 1'b0) begin
      miscompares++;
      $display("FAIL sb_issue_cycle got %b want 0", rdbusy_b[1]);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 9);
    vectors++;
    if (rdbusy_b !== 2'b10 || rdbusy_n !== 2'b10 || busy_b !== 32'h200 || busy_n !== 32'h200) begin
      miscompares++;
      $display("FAIL sb_set got %b %b %h %h want 10 10 200 200", rdbusy_b, rdbusy_n, busy_b, busy_n);
    end
    drive(1, 9, 32'h99, 0, 0, 0, 9);
    vectors++;
    if (rdbusy_b[1] !== 1'b0 || rdbusy_n[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL sb_wb_cycle got byp=%b nobyp=%b want 0 1", rdbusy_b[1], rdbusy_n[1]);
    end
    vectors++;
    if (busy_b[9] !== 1'b1) begin
      miscompares++;
      $display("FAIL sb_busy_raw got %b want 1", busy_b[9]);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 9);
    vectors++;
    if (rdbusy_b !== 2'b00 || rdbusy_n !== 2'b00 || busy_b !== '0 || busy_n !== '0) begin
      miscompares++;
      $display("FAIL sb_clear got %b %b %h %h want 00 00 0 0", rdbusy_b, rdbusy_n, busy_b, busy_n);
    end
    vectors++;
    if (rddata_n[63:32] !== 32'h99) begin
      miscompares++;
      $display("FAIL sb_wb_data got %h want 99", rddata_n[63:32]);
    end
  endtask

  task automatic test_set_clear();
    drive(1, 4, 32'h44, 1, 4, 4, 0);
    tick();
    drive(0, 0, 0, 0, 0, 4, 0);
    vectors++;
    if (busy_b !== 32'h10 || busy_n !== 32'h10) begin
      miscompares++;
      $display("FAIL setclr_busy got %h %h want 10", busy_b, busy_n);
    end
    vectors++;
    if (rddata_b[31:0] !== 32'h44 || rddata_n[31:0] !== 32'h44) begin
      miscompares++;
      $display("FAIL setclr_data got %h %h want 44", rddata_b[31:0], rddata_n[31:0]);
    end
    vectors++;
    if (rdbusy_b[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL setclr_rdbusy got %b want 1", rdbusy_b[0]);
    end
  endtask

  task automatic test_back_to_back();
    // Re-issue to the busy reg 4 together with a writeback to 4: a stall is
    // still needed. A writeback to reg 10, which is not busy, goes through.
    drive(1, 4, 32'h55, 1, 4, 4, 4);
    vectors++;
    if (rdbusy_b !== 2'b11 || rdbusy_n !== 2'b11) begin
      miscompares++;
      $display("FAIL b2b_issue_wb got %b %b want 11 11", rdbusy_b, rdbusy_n);
    end
    tick();
    drive(1, 10, 32'hABC, 1, 4, 4, 10);
    tick();
    drive(1, 4, 32'h66, 0, 0, 4, 10);
    vectors++;
    if (busy_b !== 32'h10 || rddata_b[63:32] !== 32'hABC || rdbusy_b !== 2'b00) begin
      miscompares++;
      $display("FAIL b2b_mid got %h %h %b want 10 abc 00", busy_b, rddata_b[63:32], rdbusy_b);
    end
    tick();
    drive(0, 0, 0, 0, 0, 4, 10);
    vectors++;
    if (busy_b !== '0 || busy_n !== '0 || rddata_b !== {32'hABC, 32'h66}) begin
      miscompares++;
      $display("FAIL b2b_final got %h %h %h want 0 0 00000abc00000066", busy_b, busy_n, rddata_b);
    end
  endtask

  initial begin
    test_reset();
    test_zero_reg();
    test_basic();
    test_bypass();
    test_scoreboard();
    test_set_clear();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the CPU's general-purpose register file, sitting in the ID stage.
- Provides NUM_RD combinational read ports and one synchronous write port from WB.
- Register 0 is hardwired to zero, and an optional write-to-read bypass is built in.
- An integrated scoreboard tracks registers with an in-flight producer, so hazard logic can stall on busy operands.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
NUM_RD, 2, number of independent read ports (1..4)
BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports; 0 = read returns old value

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_i  input  1  synchronous reset, active low
rdaddr_i  input  NUM_RD*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W]
rddata_o  output  NUM_RD*DATA_W  read data, port k at bits [k*DATA_W +: DATA_W]
rdbusy_o  output  NUM_RD  port k operand has a pending producer
regwrite_i  input  1  write enable
wraddr_i  input  ADDR_W  write address
wrdata_i  input  DATA_W  write data
issue_i  input  1  instruction with destination issued this cycle; mark destination busy
issueaddr_i  input  ADDR_W  destination of issued instruction
busy_o  output  DEPTH  full scoreboard vector, bit n = register n busy

Behaviour:
- Reset: on rising edge with rst_i==0, all DEPTH registers become 0 and all scoreboard bits become 0.
- While rst_i==0, rddata_o and rdbusy_o are forced to 0 combinationally, and regwrite_i and issue_i are ignored.
- Reset taken mid-operation discards pending writes and issues with no partial update.
- Write: at the clock edge, if regwrite_i==1, rst_i==1 and wraddr_i!=0, then reg[wraddr_i] <= wrdata_i.
  - A write to address 0 is dropped, so reg[0] stays 0 forever.
- Read: combinational, zero latency. rddata_o[k] = 0 if rdaddr_k==0, else reg[rdaddr_k].
- Bypass (BYPASS=1): if regwrite_i==1, wraddr_i==rdaddr_k and rdaddr_k!=0, then rddata_o[k] = wrdata_i in the same cycle.
  - With BYPASS=0, the read returns the old value and the new value is visible from the next cycle.
- Multiple read ports addressing the same register return identical data. Ports are fully independent.
- Scoreboard per register n at each edge, applied in priority order:
  1. n==0: busy[0] always 0.
  2. issue_i==1 && issueaddr_i==n: busy[n] <= 1. Set wins over a simultaneous clear, because a newer producer supersedes the old one.
  3. Else regwrite_i==1 && wraddr_i==n: busy[n] <= 0.
  4. Else hold.
- rdbusy_o[k] = busy[rdaddr_k].
  - When BYPASS=1 and a write to rdaddr_k occurs this cycle with no simultaneous issue to that address, rdbusy_o[k] = 0. The bypassed data is valid, so no stall is needed.
  - With BYPASS=0 the raw busy bit is reported.
- An issue to an already-busy register keeps it busy. There is no counting; a single writeback clears it.
- A writeback to a register that is not busy is legal: the data is written and busy stays 0.
- busy_o is registered state and carries no bypass adjustment.
- Widths: no arithmetic. Addresses are used unsigned and full-width. Every address value is in range because DEPTH = 2**ADDR_W.

Test Plan:
- Reset clears state: preload reg[5]=0xDEADBEEF, set busy[5], pull rst_i low for 1 cycle.
  -> rddata for addr 5 = 0 and busy_o = 0 after release. During reset, rddata_o = 0 and rdbusy_o = 0.
- Zero register: write 0x12345678 to addr 0, issue to addr 0.
  -> every port reads addr 0 as 0; busy_o[0] = 0.
- Basic write/read: write 0xA5A5A5A5 to addr 7, then in the next cycle read addr 7 on all NUM_RD ports.
  -> all ports show 0xA5A5A5A5.
- Bypass: reg[3]=0x1, same cycle write 0x2 to addr 3 with port0 reading addr 3.
  -> BYPASS=1: port0 = 0x2 same cycle. BYPASS=0: 0x1, then 0x2 next cycle.
- Scoreboard lifecycle: issue addr 9, so rdbusy=1 on the port reading 9 from the next cycle.
  - A writeback to 9 clears it: rdbusy=0 in the writeback cycle with BYPASS=1, or the next cycle with BYPASS=0.
- Simultaneous set/clear: issue addr 4 and write addr 4 in the same cycle.
  -> busy[4] = 1 afterward and reg[4] = new data.
